// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// Combinational 1-bit full subtractor cell: d = a - b - bi, with borrow-out.
module fs_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bi,
    output logic o_d,
    output logic o_bo
);

    assign o_d  = i_a ^ i_b ^ i_bi;
    assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - BIN, LSB-first, start/ready in, valid/ack out.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the o_ovf signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bo
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bo;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bo;

    assign w_accept = (r_state == IDLE) & i_start;
    assign w_last   = (r_state == SHIFT) & (r_cnt == LAST);

    fs_bit u_fs_bit (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_bi (r_br),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) w_next = SHIFT;
            end
            SHIFT: begin
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // D fills from the MSB side so bit 0 lands in place after WIDTH shifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_br  <= 1'b0;
            r_bo  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_br  <= i_bin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_bo;
            r_d   <= {w_d, r_d[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_bo <= w_bo;
        end
    end

    assign o_d  = r_d;
    assign o_bo = r_bo;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_ovf;

    // On the last bit r_a[0]/r_b[0] hold the operand MSBs and w_d is the result MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operations vs an arithmetic model.
// Define SERIAL_SUB_SIGNED_OVF_EN to also check o_ovf.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_ready;
    logic         o_valid;
    logic         i_ack;
    logic [W-1:0] o_d;
    logic         o_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         o_ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ack   (i_ack),
        .o_d     (o_d),
        .o_bo    (o_bo)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, b, input logic bin);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        return W'(diff);
    endfunction

    function automatic logic ref_bo(input logic [W-1:0] a, b, input logic bin);
        return int'(a) < (int'(b) + int'(bin));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic bin);
        int sdiff;
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
        return (sdiff > (2 ** (W - 1)) - 1) || (sdiff < -(2 ** (W - 1)));
    endfunction

    task automatic do_op(input logic [W-1:0] a, b, input logic bin, input int ack_dly, input string tag);
        int edges;
        @(negedge clk);
        check({tag, ".ready"}, o_ready, 1);
        i_a = a; i_b = b; i_bin = bin; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_a = W'($urandom); i_b = W'($urandom); i_bin = 1'($urandom);
        check({tag, ".busy"}, o_ready, 0);
        edges = 0;
        while (!o_valid && edges < W + 4) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        check({tag, ".lat"}, edges, W);
        check({tag, ".d"}, o_d, ref_d(a, b, bin));
        check({tag, ".bo"}, o_bo, ref_bo(a, b, bin));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, ".ovf"}, o_ovf, ref_ovf(a, b, bin));
`endif
        repeat (ack_dly) begin
            @(posedge clk); @(negedge clk);
        end
        if (ack_dly > 0) check({tag, ".hold_d"}, o_d, ref_d(a, b, bin));
        i_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ack = 1'b0;
        check({tag, ".post_valid"}, o_valid, 0);
        check({tag, ".post_ready"}, o_ready, 1);
    endtask

    initial begin
        int           n;
        logic         seen1;
        logic [W-1:0] d1;
        logic         bo1;

        rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_bin = 1'b0; i_ack = 1'b0;
        #23;
        check("rst.ready", o_ready, 1);
        check("rst.valid", o_valid, 0);
        check("rst.d", o_d, 0);
        check("rst.bo", o_bo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h35, 8'h12, 1'b0, 0, "t1");
        do_op(8'h12, 8'h35, 1'b0, 0, "t2a");
        do_op(8'h00, 8'h00, 1'b1, 0, "t2b");

        // Result held while ACK is low; START pulses ignored.
        @(negedge clk);
        i_a = 8'h9C; i_b = 8'h3B; i_bin = 1'b1; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (!o_valid && n < W + 4) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("t3.lat", n, W);
        for (int i = 0; i < 5; i++) begin
            i_start = 1'(i % 2 == 0);
            i_a = W'($urandom); i_b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t3.valid%0d", i), o_valid, 1);
            check($sformatf("t3.ready%0d", i), o_ready, 0);
            check($sformatf("t3.d%0d", i), o_d, ref_d(8'h9C, 8'h3B, 1'b1));
            check($sformatf("t3.bo%0d", i), o_bo, ref_bo(8'h9C, 8'h3B, 1'b1));
        end
        i_start = 1'b0;
        i_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ack = 1'b0;
        check("t3.ready_after_ack", o_ready, 1);
        check("t3.valid_after_ack", o_valid, 0);

        // Asynchronous reset in the middle of SHIFT (bit 4 of 0xAA-0x55).
        i_a = 8'hAA; i_b = 8'h55; i_bin = 1'b0; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4.ready", o_ready, 1);
        check("t4.valid", o_valid, 0);
        check("t4.d", o_d, 0);
        check("t4.bo", o_bo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        check("t4.no_valid", o_valid, 0);
        do_op(8'hAA, 8'h55, 1'b0, 0, "t4r");

        // Back-to-back with ACK tied high.
        @(negedge clk);
        i_ack = 1'b1;
        i_a = 8'hFF; i_b = 8'h01; i_bin = 1'b0; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_a = 8'h01; i_b = 8'hFF;
        n = 0; seen1 = 1'b0; d1 = '0; bo1 = 1'b0;
        while (!o_ready && n < 3 * W) begin
            if (o_valid) begin seen1 = 1'b1; d1 = o_d; bo1 = o_bo; end
            @(posedge clk); n++; @(negedge clk);
        end
        @(posedge clk); n++;
        check("t5.spacing", n, W + 2);
        check("t5.seen1", seen1, 1);
        check("t5.d1", d1, ref_d(8'hFF, 8'h01, 1'b0));
        check("t5.bo1", bo1, ref_bo(8'hFF, 8'h01, 1'b0));
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (!o_valid && n < W + 4) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("t5.lat2", n, W);
        check("t5.d2", o_d, ref_d(8'h01, 8'hFF, 1'b0));
        check("t5.bo2", o_bo, ref_bo(8'h01, 8'hFF, 1'b0));
        @(posedge clk);
        @(negedge clk);
        i_ack = 1'b0;
        check("t5.idle", o_ready, 1);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
        do_op(8'h80, 8'h01, 1'b0, 0, "t6a");
        do_op(8'h05, 8'h03, 1'b0, 0, "t6b");
`endif

        for (int k = 0; k < 24; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
